// File: rtl/classify_pkg.sv
// Shared constants for the classifier output-stage sequencer: score
// geometry, index width, error digit, watchdog limit and FSM encodings.
package classify_pkg;

    localparam int SCORE_W     = 26;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_W       = 4;
    localparam int TIMEOUT     = 255;
    localparam int WDOG_W      = 8;
    localparam int BANK_W      = NUM_CLASSES * SCORE_W;

    localparam logic [IDX_W-1:0]  ERR_NUM   = 4'hF;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE    = 3'd1;
    localparam state_t ST_WAIT     = 3'd2;
    localparam state_t ST_SELECT   = 3'd3;
    localparam state_t ST_WAIT_MAX = 3'd4;
    localparam state_t ST_DONE     = 3'd5;

endpackage

// File: rtl/score_bank.sv
// Register file holding one score per class neuron. One indexed write
// port, synchronous clear on rst, all entries read out as a packed bus.
module score_bank
    import classify_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [SCORE_W-1:0] wr_data,
    output logic [BANK_W-1:0]  rd_bank
);

    logic [SCORE_W-1:0] bank_q [NUM_CLASSES];
    logic [SCORE_W-1:0] bank_d [NUM_CLASSES];

    // Next bank contents: overwrite only the addressed entry, out-of-range indices write nothing
    always_comb begin
        bank_d = bank_q;
        if (wr_en) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (wr_idx == IDX_W'(k)) begin
                    bank_d[k] = wr_data;
                end
            end
        end
    end

    // Bank storage, zeroed on reset so an aborted run leaves nothing behind
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            bank_q <= bank_d;
        end
    end

    // Pack entries so class k sits at bits [k*SCORE_W +: SCORE_W]
    always_comb begin
        rd_bank = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            rd_bank[k*SCORE_W +: SCORE_W] = bank_q[k];
        end
    end

endmodule

// File: rtl/classify_sequencer.sv
// Output-stage controller for the digit classifier: walks the shared MAC
// through all ten class neurons, stores the scores, strobes the max
// selector and holds the winning digit until the host acknowledges it.
// Optional feature: define CLASSIFY_SEQ_TIMEOUT_EN for a watchdog that
// aborts a stalled WAIT / WAIT_MAX into DONE with result_err set.
module classify_sequencer
    import classify_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               neuron_req,
    output logic [IDX_W-1:0]   neuron_idx,
    input  logic [SCORE_W-1:0] score_in,
    input  logic               score_valid,
    output logic [BANK_W-1:0]  scores,
    output logic               sel_valid,
    input  logic               max_valid,
    input  logic [IDX_W-1:0]   max_num,
    output logic               result_valid,
    output logic [IDX_W-1:0]   result_num,
    output logic               result_err,
    input  logic               result_ack
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   result_num_q, result_num_d;
    logic               bank_we;
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic               result_err_q, result_err_d;
`endif

    // Sequencing: next state, class index, result latch and (optionally) watchdog
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        result_num_d = result_num_q;
        bank_we      = 1'b0;
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
        wdog_d       = wdog_q;
        result_err_d = result_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_ISSUE;
                    idx_d        = '0;
                    result_num_d = '0;
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
                    result_err_d = 1'b0;
`endif
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            ST_WAIT: begin
                if (score_valid) begin
                    bank_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_SELECT;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_ISSUE;
                    end
                end
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    state_d      = ST_DONE;
                    result_num_d = ERR_NUM;
                    result_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_SELECT: begin
                state_d = ST_WAIT_MAX;
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            ST_WAIT_MAX: begin
                if (max_valid) begin
                    state_d      = ST_DONE;
                    result_num_d = max_num;
                end
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
                else if (wdog_q == WDOG_LAST) begin
                    state_d      = ST_DONE;
                    result_num_d = ERR_NUM;
                    result_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
`endif
            end
            ST_DONE: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; reset returns to IDLE with a cleared result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            result_num_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            result_num_q <= result_num_d;
        end
    end

`ifdef CLASSIFY_SEQ_TIMEOUT_EN
    // Watchdog counter and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q       <= '0;
            result_err_q <= 1'b0;
        end else begin
            wdog_q       <= wdog_d;
            result_err_q <= result_err_d;
        end
    end

    assign result_err = result_err_q;
`else
    assign result_err = 1'b0;
`endif

    score_bank u_score_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we),
        .wr_idx  (idx_q),
        .wr_data (score_in),
        .rd_bank (scores)
    );

    assign busy         = (state_q != ST_IDLE);
    assign neuron_req   = (state_q == ST_ISSUE);
    assign neuron_idx   = idx_q;
    assign sel_valid    = (state_q == ST_SELECT);
    assign result_valid = (state_q == ST_DONE);
    assign result_num   = result_num_q;

endmodule

// File: tb/tb_classify_sequencer.sv
// Bench for classify_sequencer: the bench plays MAC, max selector and host,
// queues the scores/digits it hands the DUT and compares them when the
// DUT presents its bank and result.
module tb_classify_sequencer;
   import classify_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               busy;
   logic               neuron_req;
   logic [IDX_W-1:0]   neuron_idx;
   logic [SCORE_W-1:0] score_in;
   logic               score_valid;
   logic [BANK_W-1:0]  scores;
   logic               sel_valid;
   logic               max_valid;
   logic [IDX_W-1:0]   max_num;
   logic               result_valid;
   logic [IDX_W-1:0]   result_num;
   logic               result_err;
   logic               result_ack;

   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int sel_count = 0;

   logic [SCORE_W-1:0] exp_q [$];
   logic [IDX_W-1:0]   res_q [$];
   logic [SCORE_W-1:0] base_scores [NUM_CLASSES] =
      '{26'd0, 26'd1, 26'd2, 26'd3, 26'd4, 26'h205, 26'd6, 26'd7, 26'h208, 26'd9};

   classify_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .busy         (busy),
      .neuron_req   (neuron_req),
      .neuron_idx   (neuron_idx),
      .score_in     (score_in),
      .score_valid  (score_valid),
      .scores       (scores),
      .sel_valid    (sel_valid),
      .max_valid    (max_valid),
      .max_num      (max_num),
      .result_valid (result_valid),
      .result_num   (result_num),
      .result_err   (result_err),
      .result_ack   (result_ack)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Count selector strobes mid-cycle so double pulses are caught
   always @(negedge clk) begin
      if (sel_valid === 1'b1) sel_count++;
   end

   // Hard stop in case the run wedges somewhere unbounded
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: observed no finish required finish");
      $fatal(1, "[TB] global timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic checkOutput(input string tag, input logic [BANK_W-1:0] obs, input logic [BANK_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_busy"},         BANK_W'(busy),         '0);
      checkOutput({tag, "_neuron_req"},   BANK_W'(neuron_req),   '0);
      checkOutput({tag, "_neuron_idx"},   BANK_W'(neuron_idx),   '0);
      checkOutput({tag, "_scores"},       scores,                '0);
      checkOutput({tag, "_sel_valid"},    BANK_W'(sel_valid),    '0);
      checkOutput({tag, "_result_valid"}, BANK_W'(result_valid), '0);
      checkOutput({tag, "_result_num"},   BANK_W'(result_num),   '0);
      checkOutput({tag, "_result_err"},   BANK_W'(result_err),   '0);
   endtask

   task automatic waitReq(input int k);
      int n = 0;
      while (neuron_req !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checkOutput("req_seen", BANK_W'(neuron_req), BANK_W'(1));
      checkOutput("req_idx",  BANK_W'(neuron_idx), BANK_W'(k));
   endtask

   // Act as the MAC for one class: answer lat cycles after the request
   task automatic serviceClass(input int k, input int lat, input bit inject, input bit pulse,
                               input logic [SCORE_W-1:0] val);
      waitReq(k);
      if (inject) begin
         score_valid = 1'b1;
         score_in    = '1;
      end
      tick();
      score_valid = 1'b0;
      checkOutput("idx_hold_wait", BANK_W'(neuron_idx), BANK_W'(k));
      for (int j = 1; j < lat; j++) begin
         start      = pulse;
         result_ack = pulse;
         tick();
      end
      start       = 1'b0;
      result_ack  = 1'b0;
      score_valid = 1'b1;
      score_in    = val;
      exp_q.push_back(val);
      tick();
      score_valid = 1'b0;
      score_in    = '0;
   endtask

   // One complete classification from start to acknowledged result
   task automatic applyStimulus(input bit rand_lat, input bit inject, input bit pulse, input logic [IDX_W-1:0] ans);
      int                sel_before;
      int                t0;
      int                lat;
      logic [SCORE_W-1:0] val;
      logic [BANK_W-1:0]  exp_bank;
      sel_before = sel_count;
      exp_bank   = '0;
      if (inject) begin
         score_valid = 1'b1;
         score_in    = '1;
      end
      start = 1'b1;
      t0    = cyc;
      tick();
      start       = 1'b0;
      score_valid = 1'b0;
      checkOutput("busy_after_start", BANK_W'(busy), BANK_W'(1));
      for (int k = 0; k < NUM_CLASSES; k++) begin
         lat = rand_lat ? int'($urandom_range(5, 1)) : 1;
         val = rand_lat ? SCORE_W'($urandom) : base_scores[k];
         serviceClass(k, lat, inject, pulse, val);
      end
      checkOutput("sel_valid", BANK_W'(sel_valid), BANK_W'(1));
      if (!rand_lat) checkOutput("sel_cycle", BANK_W'(cyc - t0), BANK_W'(21));
      for (int k = 0; k < NUM_CLASSES; k++) begin
         if (exp_q.size() > 0) exp_bank[k*SCORE_W +: SCORE_W] = exp_q.pop_front();
      end
      checkOutput("scores", scores, exp_bank);
      tick();
      checkOutput("sel_one_cycle", BANK_W'(sel_valid), '0);
      start      = pulse;
      result_ack = pulse;
      tick();
      tick();
      start      = 1'b0;
      result_ack = 1'b0;
      checkOutput("wait_max_busy", BANK_W'(busy), BANK_W'(1));
      max_valid = 1'b1;
      max_num   = ans;
      res_q.push_back(ans);
      tick();
      max_valid = 1'b0;
      max_num   = '0;
      checkOutput("result_valid", BANK_W'(result_valid), BANK_W'(1));
      checkOutput("result_num",   BANK_W'(result_num),   BANK_W'(res_q.pop_front()));
      checkOutput("result_err",   BANK_W'(result_err),   '0);
      checkOutput("scores_stable", scores, exp_bank);
      start = pulse;
      tick();
      tick();
      start = 1'b0;
      checkOutput("result_hold", BANK_W'(result_valid), BANK_W'(1));
      result_ack = 1'b1;
      start      = 1'b1;
      tick();
      result_ack = 1'b0;
      start      = 1'b0;
      checkOutput("busy_after_ack",    BANK_W'(busy),         '0);
      checkOutput("result_valid_drop", BANK_W'(result_valid), '0);
      tick();
      checkOutput("idle_after_ack",  BANK_W'(busy),       '0);
      checkOutput("result_num_held", BANK_W'(result_num), BANK_W'(ans));
      checkOutput("sel_pulse_count", BANK_W'(sel_count - sel_before), BANK_W'(1));
   endtask

   initial begin
      int sel_before;
      int n;
      rst         = 1'b1;
      start       = 1'b0;
      score_in    = '0;
      score_valid = 1'b0;
      max_valid   = 1'b0;
      max_num     = '0;
      result_ack  = 1'b0;
      tick();
      tick();
      checkAllZero("reset");
      rst = 1'b0;
      tick();

      $display("[TB] normal run, 1-cycle MAC");
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd8);

      $display("[TB] variable latency with stray score_valid pulses");
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd3);

      $display("[TB] start pulsed in WAIT and DONE, back-to-back runs");
      applyStimulus(1'b1, 1'b0, 1'b1, 4'd5);
      applyStimulus(1'b0, 1'b1, 1'b1, 4'd0);

      $display("[TB] reset in WAIT at idx 5");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) serviceClass(k, 1, 1'b0, 1'b0, base_scores[k]);
      waitReq(5);
      tick();
      checkOutput("idx5_in_wait", BANK_W'(neuron_idx), BANK_W'(5));
      exp_q.delete();
      sel_before = sel_count;
      rst = 1'b1;
      tick();
      checkAllZero("mid_reset");
      rst = 1'b0;
      repeat (30) tick();
      checkOutput("no_sel_after_reset", BANK_W'(sel_count - sel_before), '0);
      checkOutput("idle_after_reset",   BANK_W'(busy),                     '0);

      $display("[TB] score withheld for idx 3");
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 3; k++) serviceClass(k, 1, 1'b0, 1'b0, base_scores[k]);
      exp_q.delete();
      waitReq(3);
      tick();
      n = 0;
`ifdef CLASSIFY_SEQ_TIMEOUT_EN
      while (result_valid !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      checkOutput("timeout_cycles", BANK_W'(n),            BANK_W'(TIMEOUT));
      checkOutput("timeout_err",    BANK_W'(result_err),   BANK_W'(1));
      checkOutput("timeout_num",    BANK_W'(result_num),   BANK_W'(ERR_NUM));
      result_ack = 1'b1;
      tick();
      result_ack = 1'b0;
      checkOutput("timeout_ack_idle", BANK_W'(busy), '0);
`else
      repeat (300) begin
         tick();
         n++;
      end
      checkOutput("stall_busy",         BANK_W'(busy),         BANK_W'(1));
      checkOutput("stall_err",          BANK_W'(result_err),   '0);
      checkOutput("stall_result_valid", BANK_W'(result_valid), '0);
      checkOutput("stall_idx",          BANK_W'(neuron_idx),   BANK_W'(3));
      rst = 1'b1;
      tick();
      rst = 1'b0;
`endif
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 4'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
